// File: rtl/march_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | march_pkg                                                                  |
// | Shared types and the March C- element table for march_sequencer.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package march_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic       dir;      // 0 = ascending, 1 = descending
        logic [1:0] nops;
        logic       op0_rd;
        logic       op0_val;  // 0 = background, 1 = inverted background
        logic       op1_rd;
        logic       op1_val;
    } elem_desc_t;

    localparam logic c_DIR_UP = 1'b0;
    localparam logic c_DIR_DN = 1'b1;

    localparam int MARCH_ELEMS = 6;

    localparam elem_desc_t MARCH_C_TABLE [MARCH_ELEMS] = '{
        '{c_DIR_UP, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0},   // w0
        '{c_DIR_UP, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1},   // r0,w1
        '{c_DIR_UP, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0},   // r1,w0
        '{c_DIR_DN, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1},   // r0,w1
        '{c_DIR_DN, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0},   // r1,w0
        '{c_DIR_UP, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0}    // r0
    };

    // Out-of-range element indices fall back to element 0.
    function automatic elem_desc_t elem_desc(input logic [2:0] elem);
        elem_desc_t d;
        d = MARCH_C_TABLE[0];
        for (int i = 0; i < MARCH_ELEMS; i++) begin
            if (elem == 3'(i)) d = MARCH_C_TABLE[i];
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/march_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | march_addr_gen                                                             |
// | Up/down address counter: load to the start address, step, terminal flag.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module march_addr_gen #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_load_dn,
    input  logic              i_step,
    input  logic              i_dn,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_is_last
);

    localparam logic [ADDR_W-1:0] c_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= i_load_dn ? '1 : '0;
        end else if (i_step) begin
            r_addr <= i_dn ? (r_addr - c_ONE) : (r_addr + c_ONE);
        end
    end

    // Terminal is detected by value, so the counter never needs to wrap.
    assign o_addr    = r_addr;
    assign o_is_last = i_dn ? (r_addr == '0) : (r_addr == '1);

endmodule
`default_nettype wire

// File: rtl/march_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | march_sequencer                                                            |
// | March C- SRAM self-test: one op per cycle, checked reads, sticky result.   |
// | Optional: MARCH_FAIL_LOG_EN keeps address/element of the first mismatch.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module march_sequencer
    import march_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] bg,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic              mem_cs,
    output logic              mem_rwbar,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            r_state;
    state_t            w_next;
    elem_desc_t        r_desc;
    elem_desc_t        w_next_desc;
    logic [2:0]        r_elem;
    logic              r_op;
    logic [DATA_W-1:0] r_bg;
    logic              r_fail;
    logic              r_chk_pend;
    logic [DATA_W-1:0] r_chk_exp;

    logic              w_launch;
    logic              w_op_rd;
    logic              w_op_val;
    logic              w_last_op;
    logic              w_elem_end;
    logic              w_run_end;
    logic              w_load;
    logic              w_load_dn;
    logic              w_step;
    logic              w_is_last;
    logic              w_mismatch;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_word;

    assign w_next_desc = elem_desc(r_elem + 3'd1);
    assign w_op_rd     = r_op ? r_desc.op1_rd  : r_desc.op0_rd;
    assign w_op_val    = r_op ? r_desc.op1_val : r_desc.op0_val;
    assign w_word      = w_op_val ? ~r_bg : r_bg;
    assign w_last_op   = (r_desc.nops == 2'd1) || r_op;
    assign w_elem_end  = (r_state == RUN) && w_last_op && w_is_last;
    assign w_run_end   = w_elem_end && (r_elem == 3'(MARCH_ELEMS - 1));
    assign w_launch    = ((r_state == IDLE) || (r_state == DONE)) && start;
    assign w_load      = w_launch || (w_elem_end && !w_run_end);
    assign w_load_dn   = w_launch ? MARCH_C_TABLE[0].dir : w_next_desc.dir;
    assign w_step      = (r_state == RUN) && w_last_op && !w_is_last;
    assign w_mismatch  = r_chk_pend && (mem_rdata != r_chk_exp);

    march_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_load_dn (w_load_dn),
        .i_step    (w_step),
        .i_dn      (r_desc.dir),
        .o_addr    (w_addr),
        .o_is_last (w_is_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        busy      = 1'b0;
        done      = 1'b0;
        mem_cs    = 1'b0;
        mem_rwbar = 1'b1;
        mem_wdata = '0;
        case (r_state)
            IDLE: begin
                if (start) w_next = RUN;
            end
            RUN: begin
                busy      = 1'b1;
                mem_cs    = 1'b1;
                mem_rwbar = w_op_rd;
                mem_wdata = w_op_rd ? '0 : w_word;
                if (w_run_end) w_next = DRAIN;
            end
            DRAIN: begin
                busy   = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) w_next = RUN;
            end
            default: w_next = IDLE;
        endcase
    end

    assign mem_addr = w_addr;
    assign fail     = r_fail;

    // A read issued this cycle is compared against mem_rdata next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_desc     <= MARCH_C_TABLE[0];
            r_elem     <= 3'd0;
            r_op       <= 1'b0;
            r_bg       <= '0;
            r_fail     <= 1'b0;
            r_chk_pend <= 1'b0;
            r_chk_exp  <= '0;
        end else begin
            r_chk_pend <= (r_state == RUN) && w_op_rd;
            r_chk_exp  <= w_word;
            if (w_launch) begin
                r_desc <= MARCH_C_TABLE[0];
                r_elem <= 3'd0;
                r_op   <= 1'b0;
                r_bg   <= bg;
                r_fail <= 1'b0;
            end else begin
                if (w_mismatch) r_fail <= 1'b1;
                if (r_state == RUN) begin
                    r_op <= !w_last_op;
                    if (w_elem_end && !w_run_end) begin
                        r_elem <= r_elem + 3'd1;
                        r_desc <= w_next_desc;
                    end
                end
            end
        end
    end

`ifdef MARCH_FAIL_LOG_EN
    logic [ADDR_W-1:0] r_chk_addr;
    logic [2:0]        r_chk_elem;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [2:0]        r_fail_elem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_chk_addr  <= '0;
            r_chk_elem  <= 3'd0;
            r_fail_addr <= '0;
            r_fail_elem <= 3'd0;
        end else begin
            r_chk_addr <= w_addr;
            r_chk_elem <= r_elem;
            if (w_launch) begin
                r_fail_addr <= '0;
                r_fail_elem <= 3'd0;
            end else if (w_mismatch && !r_fail) begin
                r_fail_addr <= r_chk_addr;
                r_fail_elem <= r_chk_elem;
            end
        end
    end

    assign fail_addr = r_fail_addr;
    assign fail_elem = r_fail_elem;
`else
    assign fail_addr = '0;
    assign fail_elem = 3'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_march_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_march_sequencer                                                         |
// | Checks march_sequencer (N=64 and N=2) against an algorithm-level model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_march_sequencer;

`ifdef MARCH_FAIL_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    typedef struct packed {
        logic       rd;
        logic [5:0] addr;
        logic [7:0] data;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    logic start0, start1;
    logic [7:0] bg0, bg1;

    logic       busy_a, done_a, fail_a, cs_a, rw_a;
    logic [5:0] addr_a, fa_a;
    logic [2:0] fe_a;
    logic [7:0] wd_a;
    logic [7:0] rd_a = 8'h00;

    logic       busy_b, done_b, fail_b, cs_b, rw_b;
    logic [0:0] addr_b, fa_b;
    logic [2:0] fe_b;
    logic [7:0] wd_b;
    logic [7:0] rd_b = 8'h00;

    logic [7:0] mem0 [64];
    logic [7:0] mem1 [2];
    int         fault0 = 0;

    op_t q0[$];
    op_t q1[$];
    bit  mon [2];
    int  nw [2];
    int  nr [2];
    bit  exp_fail [2];
    int  exp_fa [2];
    int  exp_fe [2];
    int  n_checks = 0;
    int  n_errors = 0;

    string pat    [6] = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};
    bit    pat_dn [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    logic [1:0] v_done, v_busy, v_fail, v_cs;
    logic [5:0] v_addr  [2];
    logic [5:0] v_faddr [2];
    logic [2:0] v_felem [2];
    logic [7:0] v_wd    [2];

    assign v_done     = {done_b, done_a};
    assign v_busy     = {busy_b, busy_a};
    assign v_fail     = {fail_b, fail_a};
    assign v_cs       = {cs_b, cs_a};
    assign v_addr[0]  = addr_a;
    assign v_addr[1]  = {5'b0, addr_b};
    assign v_faddr[0] = fa_a;
    assign v_faddr[1] = {5'b0, fa_b};
    assign v_felem[0] = fe_a;
    assign v_felem[1] = fe_b;
    assign v_wd[0]    = wd_a;
    assign v_wd[1]    = wd_b;

    march_sequencer #(.ADDR_W(6), .DATA_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start0), .bg(bg0),
        .busy(busy_a), .done(done_a), .fail(fail_a),
        .fail_addr(fa_a), .fail_elem(fe_a),
        .mem_cs(cs_a), .mem_rwbar(rw_a), .mem_addr(addr_a),
        .mem_wdata(wd_a), .mem_rdata(rd_a)
    );

    march_sequencer #(.ADDR_W(1), .DATA_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start1), .bg(bg1),
        .busy(busy_b), .done(done_b), .fail(fail_b),
        .fail_addr(fa_b), .fail_elem(fe_b),
        .mem_cs(cs_b), .mem_rwbar(rw_b), .mem_addr(addr_b),
        .mem_wdata(wd_b), .mem_rdata(rd_b)
    );

    always #5 clk = ~clk;

    // SRAM models; fault 1 = bit 3 stuck-at-1 at 17, fault 2 = writes to 5 alias into 37.
    always @(posedge clk) begin
        if (cs_a) begin
            if (rw_a) begin
                rd_a <= (fault0 == 1 && addr_a == 6'd17) ? (mem0[addr_a] | 8'h08) : mem0[addr_a];
            end else begin
                mem0[addr_a] <= wd_a;
                if (fault0 == 2 && addr_a == 6'd5) mem0[37] <= wd_a;
            end
        end
        if (cs_b) begin
            if (rw_b) rd_b <= mem1[addr_b];
            else      mem1[addr_b] <= wd_b;
        end
    end

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_op(input int sel, input op_t e, input logic rw,
                            input logic [5:0] a, input logic [7:0] d);
        chk("op_rwbar", rw, e.rd);
        chk("op_addr", a, e.addr);
        if (!e.rd) begin
            chk("op_wdata", d, e.data);
            nw[sel]++;
        end else begin
            nr[sel]++;
        end
    endtask

    // Expand the algorithm into an op list and replay it on a faulty array model.
    task automatic build(input int sel, input int n, input logic [7:0] bg, input int fault);
        logic [7:0] m [64];
        logic [7:0] v;
        logic [7:0] d;
        int         a;
        byte        c;
        op_t        op;
        for (int i = 0; i < 64; i++) m[i] = 8'h00;
        if (sel == 0) q0.delete(); else q1.delete();
        exp_fail[sel] = 1'b0;
        exp_fa[sel]   = 0;
        exp_fe[sel]   = 0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < n; k++) begin
                a = pat_dn[e] ? (n - 1 - k) : k;
                for (int j = 0; j < pat[e].len(); j += 2) begin
                    c = pat[e][j+1];
                    d = (c == "1") ? ~bg : bg;
                    c = pat[e][j];
                    op.rd   = (c == "r");
                    op.addr = 6'(a);
                    op.data = d;
                    if (sel == 0) q0.push_back(op); else q1.push_back(op);
                    if (op.rd) begin
                        v = m[a];
                        if (fault == 1 && a == 17) v = v | 8'h08;
                        if (v != d && !exp_fail[sel]) begin
                            exp_fail[sel] = 1'b1;
                            exp_fa[sel]   = a;
                            exp_fe[sel]   = e;
                        end
                    end else begin
                        m[a] = d;
                        if (fault == 2 && a == 5) m[37] = d;
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        op_t op;
        if (mon[0] && cs_a) begin
            chk("a_op_expected", q0.size() > 0, 1);
            if (q0.size() > 0) begin
                op = q0.pop_front();
                check_op(0, op, rw_a, addr_a, wd_a);
            end
        end
        if (mon[1] && cs_b) begin
            chk("b_op_expected", q1.size() > 0, 1);
            if (q1.size() > 0) begin
                op = q1.pop_front();
                check_op(1, op, rw_b, {5'b0, addr_b}, wd_b);
            end
        end
    end

    task automatic launch(input int sel, input logic [7:0] bg, input int fault, input bit keep);
        build(sel, (sel == 0) ? 64 : 2, bg, fault);
        nw[sel] = 0;
        nr[sel] = 0;
        if (sel == 0) begin
            fault0 = fault;
            bg0    = bg;
            start0 = 1'b1;
        end else begin
            bg1    = bg;
            start1 = 1'b1;
        end
        @(posedge clk);
        #1;
        mon[sel] = 1'b1;
        if (!keep) begin
            if (sel == 0) start0 = 1'b0; else start1 = 1'b0;
        end
        chk("launch_busy", v_busy[sel], 1);
        chk("launch_done_clear", v_done[sel], 0);
        chk("launch_fail_clear", v_fail[sel], 0);
    endtask

    task automatic finish(input int sel, input int n, input int exp_cyc, input int pulse_at,
                          input bit lits, input logic [7:0] lit_w0, input logic [7:0] lit_w1);
        int cyc;
        cyc = 0;
        while (cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (v_done[sel]) break;
            if (cyc == pulse_at)     start0 = 1'b1;
            if (cyc == pulse_at + 1) start0 = 1'b0;
            if (cyc == exp_cyc - 1) begin
                chk("drain_cs", v_cs[sel], 0);
                chk("drain_busy", v_busy[sel], 1);
            end
            if (lits) begin
                if (cyc == 1)   chk("e0_first_wdata", v_wd[sel], lit_w0);
                if (cyc == 66)  chk("e1_first_wdata", v_wd[sel], lit_w1);
                if (cyc == 321) chk("e3_first_addr", v_addr[sel], 63);
                if (cyc == 448) chk("e3_last_addr", v_addr[sel], 0);
            end
        end
        chk("done_cycle", cyc, exp_cyc);
        chk("busy_at_done", v_busy[sel], 0);
        chk("fail_at_done", v_fail[sel], exp_fail[sel]);
        chk("fail_addr", v_faddr[sel], LOG_EN ? exp_fa[sel] : 0);
        chk("fail_elem", v_felem[sel], LOG_EN ? exp_fe[sel] : 0);
        chk("write_count", nw[sel], 5 * n);
        chk("read_count", nr[sel], 5 * n);
        chk("ops_left", (sel == 0) ? q0.size() : q1.size(), 0);
        mon[sel] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem0[i] = 8'h00;
        mem1[0] = 8'h00;
        mem1[1] = 8'h00;
        mon[0]  = 1'b0;
        mon[1]  = 1'b0;
        rst     = 1'b0;
        start0  = 1'b0;
        start1  = 1'b0;
        bg0     = 8'h00;
        bg1     = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_fail", fail_a, 0);
        chk("rst_cs", cs_a, 0);
        chk("rst_rwbar", rw_a, 1);
        chk("rst_addr", addr_a, 0);
        chk("rst_wdata", wd_a, 0);
        chk("rst_fail_addr", fa_a, 0);
        chk("rst_fail_elem", fe_a, 0);
        rst = 1'b1;
        @(negedge clk);

        // Fault-free, background 00
        launch(0, 8'h00, 0, 1'b0);
        finish(0, 64, 642, -1, 1'b1, 8'h00, 8'hFF);
        chk("t1_writes_lit", nw[0], 320);
        chk("t1_reads_lit", nr[0], 320);

        // Stuck-at-1 on bit 3 of word 17
        launch(0, 8'h00, 1, 1'b0);
        finish(0, 64, 642, -1, 1'b0, 8'h00, 8'h00);
        chk("t2_fail_lit", fail_a, 1);
        chk("t2_faddr_lit", fa_a, LOG_EN ? 17 : 0);
        chk("t2_felem_lit", fe_a, LOG_EN ? 1 : 0);

        // Background A5 with a stray start pulse mid-run
        launch(0, 8'hA5, 0, 1'b0);
        finish(0, 64, 642, 100, 1'b1, 8'hA5, 8'h5A);

        // Address alias 5 -> 37
        launch(0, 8'h00, 2, 1'b0);
        finish(0, 64, 642, -1, 1'b0, 8'h00, 8'h00);
        chk("t6_fail_lit", fail_a, 1);
        chk("t6_faddr_lit", fa_a, LOG_EN ? 37 : 0);
        chk("t6_felem_lit", fe_a, LOG_EN ? 1 : 0);

        // start held high through DONE relaunches each time
        launch(0, 8'h00, 0, 1'b1);
        finish(0, 64, 642, -1, 1'b0, 8'h00, 8'h00);
        launch(0, 8'h00, 1, 1'b1);

        // Asynchronous reset while in E3
        repeat (330) @(negedge clk);
        chk("pre_reset_fail", fail_a, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_busy", busy_a, 0);
        chk("async_rst_cs", cs_a, 0);
        chk("async_rst_fail", fail_a, 0);
        chk("async_rst_done", done_a, 0);
        mon[0] = 1'b0;
        q0.delete();
        start0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        launch(0, 8'h00, 0, 1'b0);
        finish(0, 64, 642, -1, 1'b0, 8'h00, 8'h00);

        // Two-word array
        launch(1, 8'h00, 0, 1'b0);
        finish(1, 2, 22, -1, 1'b0, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
